// File: rtl/sal_req_decoder_pkg.sv
// Shared widths, address-field positions and the queued request entry for the
// DRAM controller request front end.
package sal_req_decoder_pkg;

    localparam int ADDR_WIDTH   = 32;
    localparam int ID_WIDTH     = 4;
    localparam int LEN_WIDTH    = 4;
    localparam int OFFSET_WIDTH = 3;
    localparam int CA_WIDTH     = 10;
    localparam int BA_WIDTH     = 2;
    localparam int RA_WIDTH     = 16;

    localparam int CA_LSB = OFFSET_WIDTH;
    localparam int BA_LSB = CA_LSB + CA_WIDTH;
    localparam int RA_LSB = BA_LSB + BA_WIDTH;

    typedef struct packed {
        logic                 wr;
        logic [BA_WIDTH-1:0]  ba;
        logic [RA_WIDTH-1:0]  ra;
        logic [CA_WIDTH-1:0]  ca;
        logic [ID_WIDTH-1:0]  id;
        logic [LEN_WIDTH-1:0] len;
    } req_entry_t;

    localparam int ENTRY_WIDTH = $bits(req_entry_t);

    // Offset bits and bits above the row field are deliberately dropped.
    function automatic req_entry_t decode_req(input logic                  wr,
                                              input logic [ADDR_WIDTH-1:0] addr,
                                              input logic [ID_WIDTH-1:0]   id,
                                              input logic [LEN_WIDTH-1:0]  len);
        req_entry_t e;
        e.wr  = wr;
        e.ba  = addr[BA_LSB +: BA_WIDTH];
        e.ra  = addr[RA_LSB +: RA_WIDTH];
        e.ca  = addr[CA_LSB +: CA_WIDTH];
        e.id  = id;
        e.len = len;
        return e;
    endfunction

endpackage

// File: rtl/sal_req_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on pop_data_o whenever
// the queue is non-empty. Push while full and pop while empty are ignored.
module sal_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_s;
    logic             pop_s;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == {CNT_W{1'b0}});
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign push_s     = push_i & ~full_o;
    assign pop_s      = pop_i & ~empty_o;

    // Next-state pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless until covered by count_q.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/sal_req_decoder.sv
// AXI AW/AR request front end: round-robin arbitration, bank/row/column decode,
// and a show-ahead queue feeding the bank controller.
module sal_req_decoder
    import sal_req_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [ID_WIDTH-1:0]   awid_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic [LEN_WIDTH-1:0]  awlen_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    input  logic [ID_WIDTH-1:0]   arid_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic [LEN_WIDTH-1:0]  arlen_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic                  req_wr_o,
    output logic [BA_WIDTH-1:0]   req_ba_o,
    output logic [RA_WIDTH-1:0]   req_ra_o,
    output logic [CA_WIDTH-1:0]   req_ca_o,
    output logic [ID_WIDTH-1:0]   req_id_o,
    output logic [LEN_WIDTH-1:0]  req_len_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             last_wr_q, last_wr_d;
    logic             aw_grant_s;
    logic             ar_grant_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    req_entry_t       push_entry_s;
    req_entry_t       head_entry_s;
    logic             unused_addr_s;

    assign unused_addr_s = ^{awaddr_i[ADDR_WIDTH-1:RA_LSB+RA_WIDTH], awaddr_i[OFFSET_WIDTH-1:0],
                             araddr_i[ADDR_WIDTH-1:RA_LSB+RA_WIDTH], araddr_i[OFFSET_WIDTH-1:0]};

    // Grant selection: a lone requester wins; on contention last_wr_q picks the other side.
    always_comb begin
        aw_grant_s = 1'b0;
        ar_grant_s = 1'b0;
        if (rst_n && !fifo_full_s) begin
            if (awvalid_i && (!arvalid_i || !last_wr_q)) begin
                aw_grant_s = 1'b1;
            end else if (arvalid_i) begin
                ar_grant_s = 1'b1;
            end else begin
                aw_grant_s = 1'b0;
                ar_grant_s = 1'b0;
            end
        end else begin
            aw_grant_s = 1'b0;
            ar_grant_s = 1'b0;
        end
    end

    // Round-robin history moves only on an accepted request.
    always_comb begin
        last_wr_d = last_wr_q;
        if (aw_grant_s) begin
            last_wr_d = 1'b1;
        end else if (ar_grant_s) begin
            last_wr_d = 1'b0;
        end else begin
            last_wr_d = last_wr_q;
        end
    end

    // Round-robin history register; reset prefers the write channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_wr_q <= 1'b0;
        end else begin
            last_wr_q <= last_wr_d;
        end
    end

    assign push_entry_s = aw_grant_s ? decode_req(1'b1, awaddr_i, awid_i, awlen_i)
                                     : decode_req(1'b0, araddr_i, arid_i, arlen_i);

    sal_req_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (aw_grant_s | ar_grant_s),
        .push_data_i (push_entry_s),
        .pop_i       (req_ready_i & ~fifo_empty_s),
        .pop_data_o  (head_entry_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count_s)
    );

    assign awready_o   = aw_grant_s;
    assign arready_o   = ar_grant_s;
    assign req_valid_o = (fifo_count_s != {CNT_W{1'b0}});
    assign req_wr_o    = head_entry_s.wr;
    assign req_ba_o    = head_entry_s.ba;
    assign req_ra_o    = head_entry_s.ra;
    assign req_ca_o    = head_entry_s.ca;
    assign req_id_o    = head_entry_s.id;
    assign req_len_o   = head_entry_s.len;

endmodule
